// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Owns the architectural fetch PC for a non-overlapped front
//               end. It issues one instruction-memory request at a time,
//               hands the returned word to decode, and loads the next PC
//               that decode computes once decode accepts the word. It also
//               handles redirects (flush) from later stages, faults on a
//               misaligned target, and counts words accepted by decode.
//
// Ports       :
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   imem_req     level request to instruction memory
//   imem_addr    request address (always the fetch PC)
//   imem_ack     memory returned data for the held request
//   imem_rdata   instruction word, valid with imem_ack
//   id_valid     id_instr/id_pc hold a word for decode
//   id_instr     fetched instruction word
//   id_pc        address of id_instr
//   stall        decode hold; the word is not accepted while high
//   next_pc_in   decode-computed target, sampled only on accept
//   flush        redirect from a later stage
//   flush_pc     redirect target
//   pc_fault     sticky misaligned-target flag
//   fetch_count  words accepted by decode, wraps modulo 2^COUNT_W
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,

    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,

    output logic               id_valid,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc,
    input  logic               stall,
    input  logic [31:0]        next_pc_in,

    input  logic               flush,
    input  logic [31:0]        flush_pc,

    output logic               pc_fault,
    output logic [COUNT_W-1:0] fetch_count
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        DRAIN  = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [COUNT_W-1:0] c_count_one = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t      r_state;
    // Redirect target held while an abandoned request is still in flight.
    logic [31:0] r_pending_pc;

    // Decode accepts the held word only when it is not stalled and no
    // redirect is arriving in the same cycle.
    logic w_accept;
    logic w_target_aligned;

    assign w_accept         = id_valid && !stall && !flush;
    assign w_target_aligned = (next_pc_in[1:0] == 2'b00);

    // ------------------------------------------------------------------------
    // Sequencer: one registered process drives the state and every output.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_pending_pc <= 32'h0000_0000;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            id_valid     <= 1'b0;
            id_instr     <= 32'h0000_0000;
            id_pc        <= 32'h0000_0000;
            pc_fault     <= 1'b0;
            fetch_count  <= {COUNT_W{1'b0}};
        end else begin
            case (r_state)
                // One idle cycle out of reset, then start fetching. A flush
                // arriving here simply replaces the boot address.
                BOOT: begin
                    imem_req <= 1'b1;
                    id_valid <= 1'b0;
                    if (flush) begin
                        imem_addr <= flush_pc;
                    end
                    r_state <= FETCH;
                end

                // Request outstanding; the address is held until ack.
                FETCH: begin
                    if (flush) begin
                        id_valid <= 1'b0;
                        if (imem_ack) begin
                            // Returned word belongs to the squashed path:
                            // drop it and re-request at the target at once.
                            imem_addr <= flush_pc;
                            imem_req  <= 1'b1;
                        end else begin
                            // The memory still owes a response for the old
                            // address; remember the target and wait it out.
                            r_pending_pc <= flush_pc;
                            r_state      <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        id_instr <= imem_rdata;
                        id_pc    <= imem_addr;
                        id_valid <= 1'b1;
                        imem_req <= 1'b0;
                        r_state  <= DECODE;
                    end
                end

                // Word presented to decode; everything holds while stalled.
                DECODE: begin
                    if (flush) begin
                        id_valid  <= 1'b0;
                        imem_addr <= flush_pc;
                        imem_req  <= 1'b1;
                        pc_fault  <= 1'b0;
                        r_state   <= FETCH;
                    end else if (w_accept) begin
                        fetch_count <= fetch_count + c_count_one;
                        id_valid    <= 1'b0;
                        imem_addr   <= next_pc_in;
                        if (w_target_aligned) begin
                            imem_req <= 1'b1;
                            r_state  <= FETCH;
                        end else begin
                            // Misaligned target: park with no request until
                            // a later stage redirects us.
                            imem_req <= 1'b0;
                            pc_fault <= 1'b1;
                            r_state  <= FAULT;
                        end
                    end
                end

                // Abandoned request still in flight; req stays up with the
                // old address until the memory answers. The newest flush
                // target always wins.
                DRAIN: begin
                    id_valid <= 1'b0;
                    imem_req <= 1'b1;
                    if (imem_ack) begin
                        imem_addr <= flush ? flush_pc : r_pending_pc;
                        r_state   <= FETCH;
                    end else if (flush) begin
                        r_pending_pc <= flush_pc;
                    end
                end

                // Parked after a misaligned target; only a flush leaves.
                FAULT: begin
                    id_valid <= 1'b0;
                    if (flush) begin
                        imem_addr <= flush_pc;
                        imem_req  <= 1'b1;
                        pc_fault  <= 1'b0;
                        r_state   <= FETCH;
                    end else begin
                        imem_req <= 1'b0;
                    end
                end

                default: begin
                    // Unreachable encodings recover through BOOT.
                    imem_req <= 1'b0;
                    id_valid <= 1'b0;
                    r_state  <= BOOT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
